// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash controller: sequencer state encodings and
// default field widths, so the APB register block can size its fields to match.
package spi_pkg;

   localparam int unsigned DIV_W_DEF = 8;
   localparam int unsigned CNT_W_DEF = 6;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_TRAIL = 2'd2;

endpackage

// File: rtl/spi_halfper_tick.sv
// Half-period timer: counts enabled clk_in cycles and ticks (then wraps) when the
// count reaches div, giving one tick every div+1 cycles.
module spi_halfper_tick #(
   parameter int unsigned DIV_W = spi_pkg::DIV_W_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   assign tick = enable && !clear && (cnt_q == div);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || tick) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_sck_sequencer.sv
// SPI SCK sequencer: times SCK half-periods, frames an N-bit transfer by counting
// SCK edges, and emits registered sample/shift strobes, busy and a done pulse.
module spi_sck_sequencer
   import spi_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] nbits,
   input  logic             cpol,
   input  logic             cpha,
   output logic             sck,
   output logic             sample_stb,
   output logic             shift_stb,
   output logic             busy,
   output logic             done
);

   localparam int unsigned EDGE_W = CNT_W + 1;

   logic [1:0]        state_q, state_d;
   logic              sck_q, sck_d;
   logic              sample_q, sample_d;
   logic              shift_q, shift_d;
   logic              done_q, done_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [CNT_W-1:0]  nbits_q, nbits_d;
   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic [EDGE_W-1:0] edge_q, edge_d;

   logic              tick;
   logic              timer_clear;
   logic [EDGE_W-1:0] edge_nxt;
   logic              leading;
   logic              last_edge;

   // Timer is held cleared in IDLE so every transfer starts from a fresh half-period.
   assign timer_clear = (state_q == ST_IDLE);

   spi_halfper_tick #(
      .DIV_W (DIV_W)
   ) u_halfper_tick (
      .clk_in (clk_in),
      .rst    (rst),
      .clear  (timer_clear),
      .enable (!timer_clear),
      .div    (div_q),
      .tick   (tick)
   );

   assign edge_nxt  = edge_q + EDGE_W'(1);
   assign leading   = edge_nxt[0];
   assign last_edge = (edge_nxt == {nbits_q, 1'b0});

   always_comb begin
      state_d  = state_q;
      sck_d    = sck_q;
      sample_d = 1'b0;
      shift_d  = 1'b0;
      done_d   = 1'b0;
      div_d    = div_q;
      nbits_d  = nbits_q;
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
      edge_d   = edge_q;
      case (state_q)
         ST_IDLE: begin
            sck_d = cpol;
            if (start && !abort) begin
               if (nbits != '0) begin
                  div_d   = div;
                  nbits_d = nbits;
                  cpol_d  = cpol;
                  cpha_d  = cpha;
                  edge_d  = '0;
                  state_d = ST_RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               sck_d   = cpol_q;
               state_d = ST_IDLE;
            end else if (tick) begin
               sck_d  = ~sck_q;
               edge_d = edge_nxt;
               if (cpha_q) begin
                  shift_d  = leading;
                  sample_d = !leading;
               end else begin
                  sample_d = leading;
                  shift_d  = !leading && !last_edge;
               end
               if (last_edge) begin
                  state_d = ST_TRAIL;
               end
            end
         end
         ST_TRAIL: begin
            sck_d = cpol_q;
            if (abort) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         sck_q    <= 1'b0;
         sample_q <= 1'b0;
         shift_q  <= 1'b0;
         done_q   <= 1'b0;
         div_q    <= '0;
         nbits_q  <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         edge_q   <= '0;
      end else begin
         state_q  <= state_d;
         sck_q    <= sck_d;
         sample_q <= sample_d;
         shift_q  <= shift_d;
         done_q   <= done_d;
         div_q    <= div_d;
         nbits_q  <= nbits_d;
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         edge_q   <= edge_d;
      end
   end

   assign sck        = sck_q;
   assign sample_stb = sample_q;
   assign shift_stb  = shift_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;

endmodule

// File: tb/tb_spi_sck_sequencer.sv
// Directed bench for spi_sck_sequencer: counts SCK toggles, strobes, busy cycles and
// done timing per transfer and compares them with hand-computed values.
module tb_spi_sck_sequencer;

   localparam int unsigned DIV_W = 8;
   localparam int unsigned CNT_W = 6;

   logic             clk_in = 1'b0;
   logic             rst    = 1'b0;
   logic             start  = 1'b0;
   logic             abort  = 1'b0;
   logic [DIV_W-1:0] div    = '0;
   logic [CNT_W-1:0] nbits  = '0;
   logic             cpol   = 1'b0;
   logic             cpha   = 1'b0;
   logic             sck, sample_stb, shift_stb, busy, done;

   int total = 0;
   int bad   = 0;

   int   cyc, n_tog, first_tog, n_samp, n_shift, n_lvl_bad, n_busy, n_done, done_at;
   logic prev_sck;

   spi_sck_sequencer #(
      .DIV_W (DIV_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .div        (div),
      .nbits      (nbits),
      .cpol       (cpol),
      .cpha       (cpha),
      .sck        (sck),
      .sample_stb (sample_stb),
      .shift_stb  (shift_stb),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called just after the acceptance edge; that observation is cycle 0.
   task automatic begin_watch();
      cyc       = 0;
      n_tog     = 0;
      first_tog = -1;
      n_samp    = 0;
      n_shift   = 0;
      n_lvl_bad = 0;
      n_busy    = (busy === 1'b1) ? 1 : 0;
      n_done    = (done === 1'b1) ? 1 : 0;
      done_at   = (done === 1'b1) ? 0 : -1;
      prev_sck  = sck;
   endtask

   // Strobes must coincide with an SCK toggle and leave SCK at the given level.
   task automatic watch(input int n, input logic samp_lvl, input logic shift_lvl);
      for (int i = 0; i < n; i++) begin
         step();
         cyc++;
         if (sck !== prev_sck) begin
            n_tog++;
            if (first_tog < 0) first_tog = cyc;
         end
         if (sample_stb === 1'b1) begin
            n_samp++;
            if (sck !== samp_lvl || sck === prev_sck) n_lvl_bad++;
         end
         if (shift_stb === 1'b1) begin
            n_shift++;
            if (sck !== shift_lvl || sck === prev_sck) n_lvl_bad++;
         end
         if (busy === 1'b1) n_busy++;
         if (done === 1'b1) begin
            n_done++;
            done_at = cyc;
         end
         prev_sck = sck;
      end
   endtask

   task automatic launch(input int d, input int nb, input logic pol, input logic pha);
      div   = DIV_W'(d);
      nbits = CNT_W'(nb);
      cpol  = pol;
      cpha  = pha;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      // Reset values
      #2;
      chk("rst_sck", sck, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {sample_stb, shift_stb}, 0);
      chk("rst_done", done, 0);
      step();
      rst = 1'b1;
      step();

      // div=1 nbits=8 cpol=0 cpha=0
      launch(1, 8, 1'b0, 1'b0);
      chk("t1_busy_accept", busy, 1);
      begin_watch();
      watch(40, 1'b1, 1'b0);
      chk("t1_toggles", n_tog, 16);
      chk("t1_first_rise", first_tog, 2);
      chk("t1_samples", n_samp, 8);
      chk("t1_shifts", n_shift, 7);
      chk("t1_strobe_edges", n_lvl_bad, 0);
      chk("t1_done_at", done_at, 34);
      chk("t1_done_cnt", n_done, 1);
      chk("t1_busy_cycles", n_busy, 34);

      // div=0 nbits=3 cpol=1 cpha=1
      cpol = 1'b1;
      step();
      step();
      chk("t2_idle_high", sck, 1);
      launch(0, 3, 1'b1, 1'b1);
      begin_watch();
      watch(12, 1'b1, 1'b0);
      chk("t2_toggles", n_tog, 6);
      chk("t2_first_tog", first_tog, 1);
      chk("t2_samples", n_samp, 3);
      chk("t2_shifts", n_shift, 3);
      chk("t2_strobe_edges", n_lvl_bad, 0);
      chk("t2_done_at", done_at, 7);
      chk("t2_busy_cycles", n_busy, 7);
      chk("t2_sck_end", sck, 1);

      // nbits=0
      cpol = 1'b0;
      step();
      step();
      launch(3, 0, 1'b0, 1'b0);
      begin_watch();
      watch(10, 1'b1, 1'b0);
      chk("t3_done_at", done_at, 0);
      chk("t3_done_cnt", n_done, 1);
      chk("t3_busy", n_busy, 0);
      chk("t3_strobes", n_samp + n_shift, 0);
      chk("t3_toggles", n_tog, 0);

      // abort on cycle 10 of a div=2 nbits=4 transfer
      launch(2, 4, 1'b0, 1'b0);
      begin_watch();
      watch(9, 1'b1, 1'b0);
      chk("t4_pre_samples", n_samp, 2);
      chk("t4_pre_shifts", n_shift, 1);
      chk("t4_pre_sck", sck, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t4_abort_busy", busy, 0);
      chk("t4_abort_sck", sck, 0);
      chk("t4_abort_strobes", {sample_stb, shift_stb, done}, 0);
      begin_watch();
      watch(20, 1'b1, 1'b0);
      chk("t4_post_quiet", n_samp + n_shift + n_done + n_tog + n_busy, 0);
      launch(2, 4, 1'b0, 1'b0);
      begin_watch();
      watch(32, 1'b1, 1'b0);
      chk("t4_re_toggles", n_tog, 8);
      chk("t4_re_samples", n_samp, 4);
      chk("t4_re_shifts", n_shift, 3);
      chk("t4_re_done_at", done_at, 27);
      chk("t4_re_busy", n_busy, 27);
      chk("t4_re_strobe_edges", n_lvl_bad, 0);

      // start + abort together in IDLE: abort wins
      div   = 8'd1;
      nbits = 6'd8;
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("t4b_both_busy", busy, 0);

      // second start mid-transfer is ignored
      launch(1, 8, 1'b0, 1'b0);
      begin_watch();
      watch(5, 1'b1, 1'b0);
      start = 1'b1;
      nbits = 6'd2;
      div   = 8'd0;
      watch(1, 1'b1, 1'b0);
      start = 1'b0;
      watch(40, 1'b1, 1'b0);
      chk("t5_toggles", n_tog, 16);
      chk("t5_samples", n_samp, 8);
      chk("t5_shifts", n_shift, 7);
      chk("t5_done_at", done_at, 34);
      chk("t5_busy_cycles", n_busy, 34);

      // async reset mid-RUN with cpol=1
      cpol = 1'b1;
      step();
      launch(1, 8, 1'b1, 1'b0);
      begin_watch();
      watch(5, 1'b0, 1'b1);
      chk("t6_pre_sck", sck, 1);
      chk("t6_pre_busy", busy, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rst_sck", sck, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_strobes", {sample_stb, shift_stb, done}, 0);
      step();
      rst = 1'b1;
      step();
      chk("t6_idle_cpol", sck, 1);
      begin_watch();
      watch(40, 1'b0, 1'b1);
      chk("t6_post_quiet", n_done + n_busy + n_samp + n_shift, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_sck_sequencer.md
Name: spi_sck_sequencer

Overview:
Sequences the SPI serial clock for one flash transfer, downstream of the APB register block. It counts system clocks to time SCK half-periods and counts SCK edges to frame an N-bit transfer. It emits single-cycle sample and shift strobes for the shift-register datapath, plus a busy flag and a done pulse. SCK is a registered output toggled from the system clock, never a derived clock used as a clock.

Parameters:
DIV_W, 8, width of the half-period divisor input.
CNT_W, 6, width of the bit-count input; maximum transfer is 2^CNT_W-1 bits.

Ports:
clk_in  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a transfer.
abort  input  1  terminate the current transfer immediately.
div  input  DIV_W  half-period of SCK in clk_in cycles, minus 1.
nbits  input  CNT_W  number of bits to transfer.
cpol  input  1  SCK idle level.
cpha  input  1  0: sample on leading edge; 1: shift on leading edge.
sck  output  1  serial clock to the pad.
sample_stb  output  1  one-cycle pulse: datapath captures MISO.
shift_stb  output  1  one-cycle pulse: datapath advances MOSI.
busy  output  1  high while a transfer is in progress.
done  output  1  one-cycle pulse at normal completion.

Behaviour:
- Reset: state IDLE, sck=0, sample_stb=0, shift_stb=0, busy=0, done=0, and all counters 0.
- States: IDLE, RUN, TRAIL.
- IDLE: sck is cpol, registered one cycle late. busy=0.
- start in IDLE with nbits!=0: latch div, nbits, cpol and cpha; clear the half-period and edge counters; go to RUN. busy=1 from the next cycle.
- start in IDLE with nbits==0: no SCK activity; done=1 for one cycle on the next cycle; stay in IDLE.
- start while busy is ignored. Latched values do not change mid-transfer.
- RUN: the half-period counter increments each cycle. When it equals div_q, it wraps to 0, sck toggles, and the edge counter increments. Half-period = div_q+1 cycles; div=0 gives SCK = clk_in/2.
- Edge k (1..2*nbits_q): odd k is a leading edge, even k is a trailing edge.
- Strobes are registered and assert on the same clock edge that sck toggles.
- cpha_q=0: sample_stb on every leading edge; shift_stb on every trailing edge except the last. The datapath preloads the first bit at start.
- cpha_q=1: shift_stb on every leading edge; sample_stb on every trailing edge.
- Totals per transfer: exactly nbits_q sample_stb. shift_stb count is nbits_q-1 for cpha_q=0 and nbits_q for cpha_q=1.
- After edge 2*nbits_q, go to TRAIL. TRAIL holds sck at cpol_q for div_q+1 cycles (chip-select hold). At the end of TRAIL, done=1 for one cycle and busy=0 on the same edge; return to IDLE.
- Latency: done asserts (2*nbits_q+1)*(div_q+1) cycles after the start-acceptance edge.
- abort in RUN or TRAIL: on the next edge, go to IDLE with busy=0, sck=cpol_q, and no done or strobe pulses. abort in IDLE is ignored.
- start and abort asserted together in IDLE: abort wins and start is ignored.
- Async reset mid-transfer: outputs return to reset values at once. No done is issued.
- Counter widths: the edge counter is CNT_W+1 bits so that 2*nbits cannot overflow.

Decomposition:
- Shared package spi_pkg holds the state encodings (ST_IDLE, ST_RUN, ST_TRAIL) and the DIV_W/CNT_W defaults, so the APB register block can size its fields from them.
- One sub-module, spi_halfper_tick, contains the DIV_W counter. It has clear and enable inputs and a tick output that fires when the count equals div_q. It is reused in both RUN and TRAIL.

Test Plan:
- div=1, nbits=8, cpol=0, cpha=0, start pulse:
  - sck period is 4 cycles with 16 toggles, first rise 2 cycles after acceptance.
  - 8 sample_stb on rising edges, 7 shift_stb on falling edges.
  - done 34 cycles after acceptance; busy high for exactly those 34 cycles.
- div=0, nbits=3, cpol=1, cpha=1:
  - sck idles high and toggles every cycle.
  - 3 shift_stb on falling edges, 3 sample_stb on rising edges.
  - done 7 cycles after acceptance.
- nbits=0, start: done pulse on the next cycle; sck, busy and both strobes stay low.
- div=2, nbits=4, abort asserted on cycle 10:
  - next cycle busy=0 and sck=cpol.
  - no done and no further strobes.
  - a new start afterwards runs a full, correct transfer.
- During a div=1, nbits=8 transfer, pulse start again with nbits=2: ignored; the edge count is still 16 and done timing is unchanged.
- rst low mid-RUN:
  - immediately sck=0, busy=0 and no strobes.
  - after release, IDLE sck follows cpol within 1 cycle.
